mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- MEM-stage data-memory controller between the EXE/MEM pipeline register outputs and the MEM/WB register inputs.
- Turns MEM_MemRead / MEM_MemWrite / MEM_MemByte / MEM_MemHalf / MEM_MemSignExt plus the address and store data into a data-bus request with byte enables.
- Waits for the bus handshake, aligns and extends load data into MEM_ReadData, and drives MEM_Stall to hold the pipeline until the access completes.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: cycles the controller waits in WAIT for DataMem_Ready before aborting. Range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- MEM_MemRead  in  1  load in MEM
- MEM_MemWrite  in  1  store in MEM
- MEM_MemByte  in  1  byte-sized access
- MEM_MemHalf  in  1  halfword-sized access (ignored if MEM_MemByte=1)
- MEM_MemSignExt  in  1  sign-extend load data (0 = zero-extend)
- MEM_ALU_Result  in  32  effective byte address
- MEM_ReadData2  in  32  store data (rt)
- DataMem_Ready  in  1  bus completes the current request this cycle
- DataMem_ReadData  in  32  bus read word, valid when DataMem_Ready=1
- DataMem_Address  out  30  word address = MEM_ALU_Result[31:2]
- DataMem_Read  out  1  read request
- DataMem_WE  out  4  byte write enables, bit 3 = bits 31:24
- DataMem_WriteData  out  32  lane-replicated store data
- MEM_ReadData  out  32  aligned and extended load result, to MEM/WB
- MEM_Stall  out  1  hold EXE/MEM and upstream stages
- MEM_Exc_AdEL  out  1  misaligned load
- MEM_Exc_AdES  out  1  misaligned store
- MEM_BusError  out  1  access aborted by timeout

Behaviour:
- Reset: rst=1 at a clock edge puts the FSM in IDLE and clears the counter and the read-data register. All outputs go to 0, including when reset is asserted mid-access.
- Byte order is big-endian. off = MEM_ALU_Result[1:0].
- Access is active when MEM_MemRead or MEM_MemWrite is 1. If both are 1, the write is performed and the read is ignored (MEM_ReadData=0).
- Misalignment:
  - halfword with off[0]=1, or word with off != 0.
  - In IDLE, asserts MEM_Exc_AdEL (load) or MEM_Exc_AdES (store) combinationally.
  - No bus request, no stall, MEM_ReadData=0, FSM stays in IDLE.
- Store lanes:
  - byte: WriteData = {4{rt[7:0]}}, WE = 4'b1000 >> off.
  - half: WriteData = {2{rt[15:0]}}, WE = 1100 if off[1]=0, else 0011.
  - word: WriteData = rt, WE = 1111.
- Load select on the latched word w:
  - byte: w[31-8*off -: 8].
  - half: w[31:16] if off[1]=0, else w[15:0].
  - word: w.
  - Sign- or zero-extend to 32 bits per MEM_MemSignExt.
- FSM states IDLE, WAIT, DONE:
  - IDLE, aligned access: drive the request (DataMem_Read or DataMem_WE != 0) and MEM_Stall=1.
    - If DataMem_Ready=1 in that cycle, latch DataMem_ReadData and go to DONE.
    - Otherwise clear the counter and go to WAIT.
  - WAIT: hold the request and MEM_Stall=1; increment the counter.
    - DataMem_Ready=1: latch the data, go to DONE.
    - Counter reaches TIMEOUT_CYCLES-1 without Ready: deassert the request, set the bus-error flag, go to DONE.
    - Ready on the same cycle as the timeout: Ready wins, no error.
  - DONE: request deasserted, MEM_Stall=0, MEM_ReadData valid from the latched word.
    - MEM_BusError=1 for this single cycle if the access was aborted; MEM_ReadData=0 in that case.
    - Next state is IDLE unconditionally. The instruction advances at this edge.
- Request outputs are 0 in DONE and when idle; DataMem_Address is always driven.
- Inputs are assumed stable while MEM_Stall=1, because EXE/MEM holds them.
- Latency: minimum 1 stall cycle per memory op (Ready in IDLE). Non-memory instructions pass with 0 stall.
- A new access can start in the cycle right after DONE.

Test Plan:
- lw, addr 0x100, Ready in IDLE cycle, bus word 0xDEADBEEF -> Stall=1 for 1 cycle; DONE cycle MEM_ReadData=0xDEADBEEF, Stall=0.
- lb signed, addr 0x103, word 0x123456F0, Ready after 3 WAIT cycles -> Stall=1 for 4 cycles; ReadData=0xFFFFFFF0. Same with lbu -> 0x000000F0.
- sh, addr 0x202, rt=0xAAAA5678 -> DataMem_WE=0011, WriteData=0x56785678, Address=0x80; sb, addr 0x201, rt=0x11 -> WE=0100, WriteData=0x11111111.
- lw at 0x102 -> AdEL=1, no DataMem_Read, Stall=0, ReadData=0; sh at 0x301 -> AdES=1, WE=0000.
- Read with Ready never asserted, TIMEOUT_CYCLES=4 -> request held 5 cycles (IDLE + 4 WAIT), then DONE with BusError=1 for 1 cycle, ReadData=0, then IDLE.
- rst=1 during WAIT -> next cycle Stall=0, DataMem_Read=0, FSM IDLE; a new lw completes normally afterwards.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage controller and the memory.
// Request side driven by master, completion side by slave.
interface mem_access_ctrl_if;
  logic [29:0] DataMem_Address;
  logic        DataMem_Read;
  logic [3:0]  DataMem_WE;
  logic [31:0] DataMem_WriteData;
  logic        DataMem_Ready;
  logic [31:0] DataMem_ReadData;

  modport master (
    output DataMem_Address,
    output DataMem_Read,
    output DataMem_WE,
    output DataMem_WriteData,
    input  DataMem_Ready,
    input  DataMem_ReadData
  );

  modport slave (
    input  DataMem_Address,
    input  DataMem_Read,
    input  DataMem_WE,
    input  DataMem_WriteData,
    output DataMem_Ready,
    output DataMem_ReadData
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller: bus request, load alignment,
// pipeline stall, misalignment and timeout reporting.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        MEM_MemByte,
  input  logic        MEM_MemHalf,
  input  logic        MEM_MemSignExt,
  input  logic [31:0] MEM_ALU_Result,
  input  logic [31:0] MEM_ReadData2,
  mem_access_ctrl_if.master dmem,
  output logic [31:0] MEM_ReadData,
  output logic        MEM_Stall,
  output logic        MEM_Exc_AdEL,
  output logic        MEM_Exc_AdES,
  output logic        MEM_BusError
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_n;
  logic [7:0]  cnt_q, cnt_n;
  logic [31:0] rdata_q, rdata_n;
  logic        err_q, err_n;

  logic [1:0]  off;
  logic        is_byte, is_half, is_word;
  logic        is_wr, is_rd, active, misal;
  logic        req, stall, adel, ades, berr, ld_ok;
  logic [3:0]  we;
  logic [31:0] wd;
  logic [4:0]  shamt;
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [31:0] ext;

  assign off     = MEM_ALU_Result[1:0];
  assign is_byte = MEM_MemByte;
  assign is_half = MEM_MemHalf & ~MEM_MemByte;
  assign is_word = ~MEM_MemHalf & ~MEM_MemByte;
  assign is_wr   = MEM_MemWrite;
  assign is_rd   = MEM_MemRead & ~MEM_MemWrite;
  assign active  = MEM_MemRead | MEM_MemWrite;
  assign misal   = (is_half & off[0])
                 | (is_word & (off != 2'b00));

  always_comb begin
    we = 4'b1111;
    wd = MEM_ReadData2;
    unique case (1'b1)
      is_byte: begin
        we = 4'b1000 >> off;
        wd = {4{MEM_ReadData2[7:0]}};
      end
      is_half: begin
        we = off[1] ? 4'b0011 : 4'b1100;
        wd = {2{MEM_ReadData2[15:0]}};
      end
      default: begin
        we = 4'b1111;
        wd = MEM_ReadData2;
      end
    endcase
  end

  // Big-endian: byte offset 0 is bits 31:24, so the shift is 8*(3-off).
  assign shamt  = {~off, 3'b000};
  assign lane8  = rdata_q[shamt +: 8];
  assign lane16 = off[1] ? rdata_q[15:0] : rdata_q[31:16];

  always_comb begin
    ext = rdata_q;
    unique case (1'b1)
      is_byte: ext = {{24{MEM_MemSignExt & lane8[7]}}, lane8};
      is_half: ext = {{16{MEM_MemSignExt & lane16[15]}}, lane16};
      default: ext = rdata_q;
    endcase
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    rdata_n = rdata_q;
    err_n   = err_q;
    req     = 1'b0;
    stall   = 1'b0;
    adel    = 1'b0;
    ades    = 1'b0;
    berr    = 1'b0;
    ld_ok   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        err_n = 1'b0;
        if (active && misal) begin
          adel = ~is_wr;
          ades = is_wr;
        end else if (active) begin
          req   = 1'b1;
          stall = 1'b1;
          if (dmem.DataMem_Ready) begin
            rdata_n = dmem.DataMem_ReadData;
            state_n = S_DONE;
          end else begin
            cnt_n   = 8'd0;
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req   = 1'b1;
        stall = 1'b1;
        cnt_n = cnt_q + 8'd1;
        // Ready takes priority over a coincident timeout.
        if (dmem.DataMem_Ready) begin
          rdata_n = dmem.DataMem_ReadData;
          state_n = S_DONE;
        end else if (cnt_q == LIMIT) begin
          err_n   = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        berr    = err_q;
        ld_ok   = is_rd & ~err_q;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
    end
  end

  logic req_g;
  assign req_g = req & ~rst;

  assign dmem.DataMem_Address   = MEM_ALU_Result[31:2];
  assign dmem.DataMem_Read      = req_g & is_rd;
  assign dmem.DataMem_WE        = (req_g & is_wr) ? we : 4'b0000;
  assign dmem.DataMem_WriteData = (req_g & is_wr) ? wd : 32'd0;

  assign MEM_Stall    = stall & ~rst;
  assign MEM_Exc_AdEL = adel & ~rst;
  assign MEM_Exc_AdES = ades & ~rst;
  assign MEM_BusError = berr & ~rst;
  assign MEM_ReadData = (ld_ok & ~rst) ? ext : 32'd0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 4-cycle bus timeout.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr, mem_byte, mem_half, mem_sx;
  logic [31:0] alu, rt;
  logic [31:0] rdata;
  logic        stall, adel, ades, berr;

  int checks   = 0;
  int failures = 0;

  mem_access_ctrl_if dmem();

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .MEM_MemRead    (mem_rd),
    .MEM_MemWrite   (mem_wr),
    .MEM_MemByte    (mem_byte),
    .MEM_MemHalf    (mem_half),
    .MEM_MemSignExt (mem_sx),
    .MEM_ALU_Result (alu),
    .MEM_ReadData2  (rt),
    .dmem           (dmem),
    .MEM_ReadData   (rdata),
    .MEM_Stall      (stall),
    .MEM_Exc_AdEL   (adel),
    .MEM_Exc_AdES   (ades),
    .MEM_BusError   (berr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_byte = 1'b0;
    mem_half = 1'b0;
    mem_sx   = 1'b0;
    alu      = 32'd0;
    rt       = 32'd0;
    dmem.DataMem_Ready    = 1'b0;
    dmem.DataMem_ReadData = 32'd0;
  endtask

  // Runs one access; Ready is raised in stall cycle number 'delay'
  // (0 = the IDLE cycle, -1 = never). First-cycle bus view is captured.
  task automatic access(
    input  logic rd, wr, byt, half, sx,
    input  logic [31:0] addr, data, word,
    input  int delay,
    output int stalls, output int reqs,
    output logic [31:0] res, output logic be,
    output logic [3:0] we0, output logic [31:0] wd0,
    output logic [29:0] a0, output logic rd0,
    output logic el0, output logic es0);
    mem_rd = rd; mem_wr = wr; mem_byte = byt;
    mem_half = half; mem_sx = sx; alu = addr; rt = data;
    stalls = 0; reqs = 0; res = 32'hxxxxxxxx; be = 1'bx;
    we0 = 4'h0; wd0 = 32'd0; a0 = 30'd0;
    rd0 = 1'b0; el0 = 1'b0; es0 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      dmem.DataMem_Ready    = (c == delay);
      dmem.DataMem_ReadData = word;
      @(negedge clk);
      if (c == 0) begin
        we0 = dmem.DataMem_WE;
        wd0 = dmem.DataMem_WriteData;
        a0  = dmem.DataMem_Address;
        rd0 = dmem.DataMem_Read;
        el0 = adel;
        es0 = ades;
      end
      if (dmem.DataMem_Read || dmem.DataMem_WE != 4'h0) reqs++;
      if (!stall) begin
        res = rdata;
        be  = berr;
        break;
      end
      stalls++;
      step();
    end
    step();
    idle_in();
  endtask

  int          st, rq;
  logic [31:0] res, wd0;
  logic        be, rd0, el0, es0;
  logic [3:0]  we0;
  logic [29:0] a0;

  initial begin
    idle_in();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_read", {31'd0, dmem.DataMem_Read}, 32'd0);
    check("rst_we", {28'd0, dmem.DataMem_WE}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_berr", {31'd0, berr}, 32'd0);
    step();
    rst = 1'b0;

    // lw 0x100, Ready in IDLE
    access(1, 0, 0, 0, 0, 32'h100, 0, 32'hDEADBEEF, 0,
           st, rq, res, be, we0, wd0, a0, rd0, el0, es0);
    check("lw_stalls", st, 1);
    check("lw_data", res, 32'hDEADBEEF);
    check("lw_addr", {2'b0, a0}, 32'h40);
    check("lw_read", {31'd0, rd0}, 32'd1);

    // lb signed 0x103, Ready in third WAIT cycle
    access(1, 0, 1, 0, 1, 32'h103, 0, 32'h123456F0, 3,
           st, rq, res, be, we0, wd0, a0, rd0, el0, es0);
    check("lb_stalls", st, 4);
    check("lb_data", res, 32'hFFFFFFF0);

    access(1, 0, 1, 0, 0, 32'h103, 0, 32'h123456F0, 3,
           st, rq, res, be, we0, wd0, a0, rd0, el0, es0);
    check("lbu_stalls", st, 4);
    check("lbu_data", res, 32'h000000F0);

    // halfword loads, both lanes
    access(1, 0, 0, 1, 1, 32'h100, 0, 32'h80011234, 1,
           st, rq, res, be, we0, wd0, a0, rd0, el0, es0);
    check("lh_data", res, 32'hFFFF8001);
    check("lh_stalls", st, 2);
    access(1, 0, 0, 1, 0, 32'h102, 0, 32'h12348765, 0,
           st, rq, res, be, we0, wd0, a0, rd0, el0, es0);
    check("lhu_data", res, 32'h00008765);

    // stores
    access(0, 1, 0, 1, 0, 32'h202, 32'hAAAA5678, 0, 0,
           st, rq, res, be, we0, wd0, a0, rd0, el0, es0);
    check("sh_we", {28'd0, we0}, 32'h3);
    check("sh_wd", wd0, 32'h56785678);
    check("sh_addr", {2'b0, a0}, 32'h80);
    check("sh_stalls", st, 1);
    check("sh_rdata", res, 32'd0);

    access(0, 1, 1, 0, 0, 32'h201, 32'h11, 0, 0,
           st, rq, res, be, we0, wd0, a0, rd0, el0, es0);
    check("sb_we", {28'd0, we0}, 32'h4);
    check("sb_wd", wd0, 32'h11111111);

    // read+write together: write wins, no read, no load data
    access(1, 1, 0, 0, 0, 32'h104, 32'hCAFEF00D, 32'h55555555, 0,
           st, rq, res, be, we0, wd0, a0, rd0, el0, es0);
    check("rw_we", {28'd0, we0}, 32'hF);
    check("rw_wd", wd0, 32'hCAFEF00D);
    check("rw_read", {31'd0, rd0}, 32'd0);
    check("rw_rdata", res, 32'd0);

    // misaligned
    access(1, 0, 0, 0, 0, 32'h102, 0, 32'h77777777, 0,
           st, rq, res, be, we0, wd0, a0, rd0, el0, es0);
    check("mis_lw_adel", {31'd0, el0}, 32'd1);
    check("mis_lw_ades", {31'd0, es0}, 32'd0);
    check("mis_lw_read", {31'd0, rd0}, 32'd0);
    check("mis_lw_stalls", st, 0);
    check("mis_lw_rdata", res, 32'd0);
    access(0, 1, 0, 1, 0, 32'h301, 32'h1234, 0, 0,
           st, rq, res, be, we0, wd0, a0, rd0, el0, es0);
    check("mis_sh_ades", {31'd0, es0}, 32'd1);
    check("mis_sh_adel", {31'd0, el0}, 32'd0);
    check("mis_sh_we", {28'd0, we0}, 32'd0);

    // timeout: IDLE + 4 WAIT with request, then DONE with error
    access(1, 0, 0, 0, 0, 32'h400, 0, 32'h99999999, -1,
           st, rq, res, be, we0, wd0, a0, rd0, el0, es0);
    check("to_stalls", st, 5);
    check("to_reqs", rq, 5);
    check("to_berr", {31'd0, be}, 32'd1);
    check("to_rdata", res, 32'd0);
    @(negedge clk);
    check("to_berr_clr", {31'd0, berr}, 32'd0);
    check("to_idle_read", {31'd0, dmem.DataMem_Read}, 32'd0);
    step();

    // reset in the middle of WAIT
    mem_rd = 1'b1;
    alu    = 32'h500;
    step();
    step();
    @(negedge clk);
    check("rw_wait_stall", {31'd0, stall}, 32'd1);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_read", {31'd0, dmem.DataMem_Read}, 32'd0);
    step();
    rst = 1'b0;
    idle_in();
    @(negedge clk);
    check("post_rst_stall", {31'd0, stall}, 32'd0);
    check("post_rst_read", {31'd0, dmem.DataMem_Read}, 32'd0);
    step();
    access(1, 0, 0, 0, 0, 32'h600, 0, 32'h0BADF00D, 2,
           st, rq, res, be, we0, wd0, a0, rd0, el0, es0);
    check("post_rst_lw_stalls", st, 3);
    check("post_rst_lw_data", res, 32'h0BADF00D);
    check("post_rst_lw_berr", {31'd0, be}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
